shake256_block_feeder: RTL and testbench
========================================

SHAKE256_BLOCK_FEEDER -- requirements
Module: shake256_block_feeder

Interface
- REQ-001: clock  input  1  sole clock; all state updates on rising edge.
- REQ-002: reset  input  1  synchronous, active-high; sampled on the rising clock edge.
- REQ-003: in_valid  input  1  input word present.
- REQ-004: in_ready  output  1  feeder accepts the word this cycle.
- REQ-005: in_data  input  64  message word, byte 0 in bits [7:0].
- REQ-006: in_last  input  1  final word of the message.
- REQ-007: in_nbytes  input  4  valid bytes in the final word, 0..8; ignored unless in_last.
- REQ-008: message  output  1088  rate block for the sponge core; word k in bits [64k+63:64k].
- REQ-009: length  output  11  valid bits in message, 0..1088.
- REQ-010: block_valid  output  1  message/length/block_last are valid.
- REQ-011: block_ready  input  1  core takes the block (core not busy).
- REQ-012: block_last  output  1  final block of the message.

Function
- REQ-013: The FSM SHALL have exactly three states: FILL, HOLD and PADBLK.
- REQ-014: FILL: in_ready=1; each accepted word SHALL be written into word slot word_cnt (0..16), and word_cnt SHALL then increment.
- REQ-015: Bytes at or beyond in_nbytes in a last word SHALL be stored as zero; unfilled slots SHALL read zero.
- REQ-016: Acceptance into slot 16, or acceptance of any in_last word, SHALL move the FSM to HOLD; block_valid SHALL be 1 on the next cycle (1-cycle latency).
- REQ-017: Without padding, length SHALL equal 64*(full words) + 8*in_nbytes of the last word; a block closed by slot 16 without in_last SHALL carry length=1088.
- REQ-018: HOLD: in_ready=0; message, length and block_last SHALL remain stable until block_valid & block_ready.
- REQ-019: On that handshake the buffer SHALL clear, word_cnt SHALL reset to 0 and the FSM SHALL return to FILL, or go to PADBLK per REQ-025.
- REQ-020: block_last SHALL be 1 only on the block containing the message end; consecutive messages SHALL NOT share a block.
- REQ-021: in_last with in_nbytes=0 at word_cnt=0 (empty message) SHALL emit one block; without padding that block has length=0 and block_last=1.
- REQ-022: in_nbytes > 8 SHALL be treated as 8.

Reset
- REQ-023: reset SHALL, at any state including mid-block or HOLD, force: message=0, length=0, block_valid=0, block_last=0, word_cnt=0, state=FILL, in_ready=1 on the next cycle; partial data SHALL be discarded.

Configuration
- REQ-024: With SHAKE256_PAD_EN defined: byte 0x1F SHALL be XORed at message-byte index L (L = valid bytes in the final block), 0x80 SHALL be XORed into byte 135 (merging to 0x9F when L=135), and length SHALL always be 1088.
- REQ-025: With SHAKE256_PAD_EN defined and the message ending exactly on a 136-byte boundary: the full block SHALL be emitted with block_last=0, then PADBLK SHALL emit a block with byte0=0x1F, byte135=0x80, block_last=1, in_ready=0 throughout.
- REQ-026: Without SHAKE256_PAD_EN: no padding SHALL be inserted, PADBLK SHALL be unreachable, and the REQ-017 length rule SHALL apply.

Verification
- REQ-027: 3 words 0x0706050403020100, 0x0F0E..08, 0x1716..10, last with nbytes=8, block_ready=1 -> block_valid=1 one cycle after word 3; message[191:0] = bytes 0x00..0x17; length=192 (no pad) or 1088 with byte24=0x1F, byte135=0x80 (pad); block_last=1.
- REQ-028: 17 full words without in_last, then 1 word nbytes=3 last -> block 1: length=1088, block_last=0; block 2: length=24 (no pad), block_last=1.
- REQ-029: Empty message (in_last, nbytes=0) -> one block; no pad: length=0; pad: byte0=0x1F, byte135=0x80; block_last=1.
- REQ-030: 17 words, 17th with in_last, nbytes=8, SHAKE256_PAD_EN defined -> two blocks; second = 0x1F..0x80 with block_last=1; in_ready=0 until the second handshake.
- REQ-031: Hold block_ready=0 for 10 cycles in HOLD -> outputs stable, in_ready=0; then assert reset -> all outputs 0, in_ready=1 next cycle.
- REQ-032: 135 bytes with SHAKE256_PAD_EN defined (16 full words + last word nbytes=7) -> byte135=0x9F, single block, block_last=1.

Source files
------------

// File: rtl/shake256_block_feeder.sv
`default_nettype none
// ============================================================================
// Module   : shake256_block_feeder
// Purpose  : Packs 64-bit message words into 1088-bit SHAKE256 rate blocks.
//            Optional SHAKE256 padding is enabled by defining SHAKE256_PAD_EN.
// Revision : 1.0 - initial release
// ============================================================================
module shake256_block_feeder (
  input  logic          clock,
  input  logic          reset,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [63:0]   in_data,
  input  logic          in_last,
  input  logic [3:0]    in_nbytes,
  output logic [1087:0] message,
  output logic [10:0]   length,
  output logic          block_valid,
  input  logic          block_ready,
  output logic          block_last
);

  localparam logic [1:0]  FILL       = 2'd0;
  localparam logic [1:0]  HOLD       = 2'd1;
  localparam logic [1:0]  PADBLK     = 2'd2;
  localparam int unsigned RATE_WORDS = 17;
  localparam int unsigned RATE_BYTES = 136;
  localparam logic [10:0] FULL_LEN   = 11'd1088;

  logic [1:0]    state_q, state_d;
  logic [1087:0] buf_q, buf_d;
  logic [4:0]    word_cnt_q, word_cnt_d;
  logic [10:0]   len_q, len_d;
  logic          last_q, last_d;
`ifdef SHAKE256_PAD_EN
  logic          pend_q, pend_d;
  logic [7:0]    w_pad_idx;
`endif

  logic [3:0]    w_nbytes;
  logic [63:0]   w_word;
  logic          w_accept;
  logic          w_close;

  // Non-final words always carry 8 bytes; oversized counts saturate at 8.
  always_comb begin
    if (!in_last)
      w_nbytes = 4'd8;
    else if (in_nbytes > 4'd8)
      w_nbytes = 4'd8;
    else
      w_nbytes = in_nbytes;
  end

  generate
    for (genvar b = 0; b < 8; b++) begin : g_mask
      assign w_word[8*b +: 8] = (4'(b) < w_nbytes) ? in_data[8*b +: 8] : 8'h00;
    end
  endgenerate

  assign w_accept = (state_q == FILL) && in_valid;
  assign w_close  = in_last || (word_cnt_q == 5'd16);
`ifdef SHAKE256_PAD_EN
  assign w_pad_idx = {word_cnt_q, 3'b000} + {4'b0000, w_nbytes};
`endif

  always_comb begin
    state_d    = state_q;
    buf_d      = buf_q;
    word_cnt_d = word_cnt_q;
    len_d      = len_q;
    last_d     = last_q;
`ifdef SHAKE256_PAD_EN
    pend_d     = pend_q;
`endif
    case (state_q)
      FILL: begin
        if (w_accept) begin
          for (int w = 0; w < RATE_WORDS; w++) begin
            if (word_cnt_q == 5'(w))
              buf_d[64*w +: 64] = w_word;
          end
          word_cnt_d = word_cnt_q + 5'd1;
          if (w_close) begin
            state_d = HOLD;
`ifdef SHAKE256_PAD_EN
            len_d = FULL_LEN;
            if (in_last && (w_pad_idx == 8'(RATE_BYTES))) begin
              // Message fills the block exactly: padding goes in a block of its own.
              pend_d = 1'b1;
              last_d = 1'b0;
            end else if (in_last) begin
              for (int i = 0; i < RATE_BYTES; i++) begin
                if (w_pad_idx == 8'(i))
                  buf_d[8*i +: 8] = buf_d[8*i +: 8] ^ 8'h1F;
              end
              buf_d[1087:1080] = buf_d[1087:1080] ^ 8'h80;
              last_d = 1'b1;
            end else begin
              last_d = 1'b0;
            end
`else
            len_d  = {word_cnt_q, 6'b000000} + {4'b0000, w_nbytes, 3'b000};
            last_d = in_last;
`endif
          end
        end
      end
      HOLD: begin
        if (block_ready) begin
          state_d    = FILL;
          buf_d      = '0;
          word_cnt_d = 5'd0;
          len_d      = 11'd0;
          last_d     = 1'b0;
`ifdef SHAKE256_PAD_EN
          if (pend_q) begin
            state_d          = PADBLK;
            pend_d           = 1'b0;
            buf_d[7:0]       = 8'h1F;
            buf_d[1087:1080] = 8'h80;
            len_d            = FULL_LEN;
            last_d           = 1'b1;
          end
`endif
        end
      end
      PADBLK: begin
        if (block_ready) begin
          state_d    = FILL;
          buf_d      = '0;
          word_cnt_d = 5'd0;
          len_d      = 11'd0;
          last_d     = 1'b0;
        end
      end
      default: begin
        state_d    = FILL;
        buf_d      = '0;
        word_cnt_d = 5'd0;
        len_d      = 11'd0;
        last_d     = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= FILL;
      buf_q      <= '0;
      word_cnt_q <= 5'd0;
      len_q      <= 11'd0;
      last_q     <= 1'b0;
`ifdef SHAKE256_PAD_EN
      pend_q     <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      buf_q      <= buf_d;
      word_cnt_q <= word_cnt_d;
      len_q      <= len_d;
      last_q     <= last_d;
`ifdef SHAKE256_PAD_EN
      pend_q     <= pend_d;
`endif
    end
  end

  assign in_ready    = (state_q == FILL);
  assign block_valid = (state_q == HOLD) || (state_q == PADBLK);
  assign message     = buf_q;
  assign length      = len_q;
  assign block_last  = last_q;

endmodule
`default_nettype wire

// File: tb/tb_shake256_block_feeder.sv
`default_nettype none
// ============================================================================
// Module   : tb_shake256_block_feeder
// Purpose  : Directed self-checking bench for shake256_block_feeder.
// Revision : 1.0 - initial release
// ============================================================================
module tb_shake256_block_feeder;

`ifdef SHAKE256_PAD_EN
  localparam bit PAD = 1'b1;
`else
  localparam bit PAD = 1'b0;
`endif

  logic          clock = 1'b0;
  logic          reset;
  logic          in_valid;
  logic          in_ready;
  logic [63:0]   in_data;
  logic          in_last;
  logic [3:0]    in_nbytes;
  logic [1087:0] message;
  logic [10:0]   length;
  logic          block_valid;
  logic          block_ready;
  logic          block_last;

  int checks = 0;
  int errors = 0;
  logic [1087:0] exp_msg;

  shake256_block_feeder dut (
    .clock       (clock),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data     (in_data),
    .in_last     (in_last),
    .in_nbytes   (in_nbytes),
    .message     (message),
    .length      (length),
    .block_valid (block_valid),
    .block_ready (block_ready),
    .block_last  (block_last)
  );

  always #5 clock = ~clock;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic chk_msg(input string tag, input logic [1087:0] expv);
    int bad;
    bad = -1;
    for (int w = 16; w >= 0; w--)
      if (message[64*w +: 64] !== expv[64*w +: 64]) bad = w;
    checks++;
    assert (message === expv) else begin
      errors++;
      $error("FAIL %s word %0d observed=%h expected=%h", tag, bad,
             message[64*bad +: 64], expv[64*bad +: 64]);
    end
  endtask

  task automatic chk_block(input string tag, input int exp_len, input logic exp_last);
    chk({tag, "_valid"}, 64'(block_valid), 64'd1);
    chk({tag, "_len"},   64'(length),      64'(exp_len));
    chk({tag, "_last"},  64'(block_last),  64'(exp_last));
    chk({tag, "_ready"}, 64'(in_ready),    64'd0);
    chk_msg({tag, "_msg"}, exp_msg);
  endtask

  task automatic send(input logic [63:0] d, input logic last, input logic [3:0] nb);
    int n;
    n = 0;
    while (!in_ready && n < 40) begin
      tick();
      n++;
    end
    chk("in_ready_wait", 64'(in_ready), 64'd1);
    in_valid  = 1'b1;
    in_data   = d;
    in_last   = last;
    in_nbytes = nb;
    tick();
    in_valid  = 1'b0;
    in_data   = 64'd0;
    in_last   = 1'b0;
    in_nbytes = 4'd0;
  endtask

  task automatic handshake();
    block_ready = 1'b1;
    tick();
    block_ready = 1'b0;
  endtask

  function automatic logic [1087:0] padded(input logic [1087:0] m, input int nbytes_total);
    logic [1087:0] r;
    r = m;
    r[8*nbytes_total +: 8] = r[8*nbytes_total +: 8] ^ 8'h1F;
    r[1087:1080] = r[1087:1080] ^ 8'h80;
    return r;
  endfunction

  initial begin
    reset = 1'b1; in_valid = 1'b0; in_data = 64'd0; in_last = 1'b0;
    in_nbytes = 4'd0; block_ready = 1'b0;
    tick();
    tick();
    exp_msg = '0;
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_valid",    64'(block_valid), 64'd0);
    chk("rst_len",      64'(length), 64'd0);
    chk("rst_last",     64'(block_last), 64'd0);
    chk_msg("rst_msg", exp_msg);
    reset = 1'b0;
    tick();

    // Three full words, last, core always ready.
    block_ready = 1'b1;
    send(64'h0706050403020100, 1'b0, 4'd8);
    send(64'h0F0E0D0C0B0A0908, 1'b0, 4'd8);
    send(64'h1716151413121110, 1'b1, 4'd8);
    exp_msg = '0;
    exp_msg[63:0]    = 64'h0706050403020100;
    exp_msg[127:64]  = 64'h0F0E0D0C0B0A0908;
    exp_msg[191:128] = 64'h1716151413121110;
    if (PAD) exp_msg = padded(exp_msg, 24);
    chk_block("three", PAD ? 1088 : 192, 1'b1);
    tick();
    block_ready = 1'b0;
    chk("three_after_ready", 64'(in_ready), 64'd1);
    chk("three_after_valid", 64'(block_valid), 64'd0);

    // 17 full words closing on slot 16; nbytes ignored on non-final words.
    exp_msg = '0;
    for (int k = 0; k < 17; k++) begin
      send({32'hA5A55A5A, 32'(k * 3 + 1)}, 1'b0, 4'd3);
      exp_msg[64*k +: 64] = {32'hA5A55A5A, 32'(k * 3 + 1)};
    end
    chk_block("full", 1088, 1'b0);
    in_valid = 1'b1; in_data = 64'hDEADBEEFDEADBEEF;
    for (int c = 0; c < 10; c++) begin
      tick();
      chk("hold_ready", 64'(in_ready), 64'd0);
      chk_msg("hold_msg", exp_msg);
    end
    chk("hold_len", 64'(length), 64'd1088);
    in_valid = 1'b0; in_data = 64'd0;
    handshake();
    chk("full_after_valid", 64'(block_valid), 64'd0);
    exp_msg = '0;
    chk_msg("full_cleared", exp_msg);

    send(64'hFFEEDDCCBBAA9988, 1'b1, 4'd3);
    exp_msg = '0;
    exp_msg[63:0] = 64'h0000000000AA9988;
    if (PAD) exp_msg = padded(exp_msg, 3);
    chk_block("tail3", PAD ? 1088 : 24, 1'b1);
    handshake();

    // Empty message.
    send(64'h1122334455667788, 1'b1, 4'd0);
    exp_msg = '0;
    if (PAD) exp_msg = padded(exp_msg, 0);
    chk_block("empty", PAD ? 1088 : 0, 1'b1);
    handshake();
    chk("empty_after_valid", 64'(block_valid), 64'd0);

    // Oversized byte count saturates to 8.
    send(64'h0123456789ABCDEF, 1'b1, 4'd15);
    exp_msg = '0;
    exp_msg[63:0] = 64'h0123456789ABCDEF;
    if (PAD) exp_msg = padded(exp_msg, 8);
    chk_block("nb15", PAD ? 1088 : 64, 1'b1);
    handshake();

    // Reset mid-block discards the partial words.
    send(64'h1111111111111111, 1'b0, 4'd8);
    send(64'h2222222222222222, 1'b0, 4'd8);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("midrst_ready", 64'(in_ready), 64'd1);
    chk("midrst_valid", 64'(block_valid), 64'd0);
    send(64'hCAFEF00DCAFEF00D, 1'b1, 4'd8);
    exp_msg = '0;
    exp_msg[63:0] = 64'hCAFEF00DCAFEF00D;
    if (PAD) exp_msg = padded(exp_msg, 8);
    chk_block("midrst", PAD ? 1088 : 64, 1'b1);
    handshake();

    // Reset while holding a block.
    send(64'h8877665544332211, 1'b0, 4'd8);
    send(64'h99AABBCCDDEEFF00, 1'b1, 4'd5);
    exp_msg = '0;
    exp_msg[63:0]   = 64'h8877665544332211;
    exp_msg[127:64] = 64'h000000DDEEFF00 & 64'h000000FFFFFFFFFF | 64'h000000CCDDEEFF00;
    if (PAD) exp_msg = padded(exp_msg, 13);
    chk_block("holdrst", PAD ? 1088 : 104, 1'b1);
    tick();
    tick();
    chk("holdrst_stable", 64'(block_valid), 64'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    exp_msg = '0;
    chk("holdrst_ready", 64'(in_ready), 64'd1);
    chk("holdrst_valid", 64'(block_valid), 64'd0);
    chk("holdrst_len",   64'(length), 64'd0);
    chk("holdrst_last",  64'(block_last), 64'd0);
    chk_msg("holdrst_msg", exp_msg);
    tick();

`ifdef SHAKE256_PAD_EN
    // Message of exactly 136 bytes: a separate padding block follows.
    exp_msg = '0;
    for (int k = 0; k < 17; k++) begin
      send({32'h5A5A0000, 32'(k)}, (k == 16), 4'd8);
      exp_msg[64*k +: 64] = {32'h5A5A0000, 32'(k)};
    end
    chk_block("exact", 1088, 1'b0);
    handshake();
    exp_msg = '0;
    exp_msg[7:0] = 8'h1F;
    exp_msg[1087:1080] = 8'h80;
    chk_block("padblk", 1088, 1'b1);
    handshake();
    chk("padblk_after_ready", 64'(in_ready), 64'd1);
    chk("padblk_after_valid", 64'(block_valid), 64'd0);

    // 135 bytes: both pad bytes merge into 0x9F.
    for (int k = 0; k < 16; k++)
      send(64'h0101010101010101, 1'b0, 4'd8);
    send(64'hFF07060504030201, 1'b1, 4'd7);
    chk("b135_byte", 64'(message[1087:1080]), 64'h9F);
    chk("b135_last", 64'(block_last), 64'd1);
    chk("b135_word16", 64'(message[1087:1024]), 64'h9F07060504030201);
    handshake();
    chk("b135_after_valid", 64'(block_valid), 64'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
